// File: rtl/avalon_host.sv
`default_nettype none
// ----------------------------------------------------------------------------
// avalon_host : Avalon-MM master that writes a command byte, then polls status
//               until done or the poll budget expires.       Revision: 1.0
// ----------------------------------------------------------------------------
module avalon_host #(
  parameter int POLL_GAP  = 4,
  parameter int MAX_POLLS = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_byte,
  output logic        rsp_valid,
  output logic [7:0]  rsp_byte,
  output logic        rsp_error,
  output logic        rsp_timeout,
  output logic        av_chipselect,
  output logic        av_write,
  output logic        av_read,
  output logic [3:0]  av_byteenable,
  output logic [31:0] av_writedata,
  input  logic [31:0] av_readdata
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_WAIT  = 3'd2,
    S_READ  = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  localparam bit          C_HAS_GAP   = (POLL_GAP > 0);
  localparam logic [7:0]  C_GAP_LAST  = (POLL_GAP > 0) ? 8'(POLL_GAP - 1) : 8'd0;
  localparam logic [15:0] C_MAX_POLLS = 16'(MAX_POLLS);

  state_t      r_state;
  state_t      w_next_state;
  logic [7:0]  r_byte;
  logic [7:0]  r_gap;
  logic [15:0] r_polls;
  logic [7:0]  r_rsp_byte;
  logic        r_rsp_error;
  logic        r_rsp_timeout;

  logic        w_done;
  logic [15:0] w_polls_inc;
  logic        w_last_poll;
  logic        w_unused_bits;

  assign w_done        = av_readdata[8];
  assign w_polls_inc   = r_polls + 16'd1;
  assign w_last_poll   = (w_polls_inc == C_MAX_POLLS);
  assign w_unused_bits = ^{av_readdata[31:11], av_readdata[9]};

  assign rsp_byte    = r_rsp_byte;
  assign rsp_error   = r_rsp_error;
  assign rsp_timeout = r_rsp_timeout;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_byte        <= 8'd0;
      r_gap         <= 8'd0;
      r_polls       <= 16'd0;
      r_rsp_byte    <= 8'd0;
      r_rsp_error   <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_byte  <= cmd_byte;
            r_polls <= 16'd0;
          end
        end
        S_WRITE: r_gap <= 8'd0;
        S_WAIT:  r_gap <= r_gap + 8'd1;
        S_READ: begin
          r_polls <= w_polls_inc;
          r_gap   <= 8'd0;
          // Done takes priority over an expiring poll budget.
          if (w_done) begin
            r_rsp_byte    <= av_readdata[7:0];
            r_rsp_error   <= av_readdata[10];
            r_rsp_timeout <= 1'b0;
          end else if (w_last_poll) begin
            r_rsp_byte    <= 8'd0;
            r_rsp_error   <= 1'b0;
            r_rsp_timeout <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next_state  = r_state;
    cmd_ready     = 1'b0;
    rsp_valid     = 1'b0;
    av_chipselect = 1'b0;
    av_write      = 1'b0;
    av_read       = 1'b0;
    av_byteenable = 4'b0000;
    av_writedata  = 32'd0;
    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) w_next_state = S_WRITE;
      end
      S_WRITE: begin
        av_chipselect = 1'b1;
        av_write      = 1'b1;
        av_byteenable = 4'b0001;
        av_writedata  = {24'd0, r_byte};
        w_next_state  = C_HAS_GAP ? S_WAIT : S_READ;
      end
      S_WAIT: begin
        if (r_gap == C_GAP_LAST) w_next_state = S_READ;
      end
      S_READ: begin
        av_chipselect = 1'b1;
        av_read       = 1'b1;
        av_byteenable = 4'b1111;
        if (w_done || w_last_poll) w_next_state = S_RESP;
        else                       w_next_state = C_HAS_GAP ? S_WAIT : S_READ;
      end
      S_RESP: begin
        rsp_valid    = 1'b1;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_avalon_host.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_avalon_host : randomized self-checking bench for avalon_host, three
//                  parameterisations against a latency/result model. Rev 1.0
// ----------------------------------------------------------------------------
module tb_avalon_host;

  logic        clock = 1'b0;
  logic        reset;
  logic        cmd_valid     [3];
  logic        cmd_ready     [3];
  logic [7:0]  cmd_byte      [3];
  logic        rsp_valid     [3];
  logic [7:0]  rsp_byte      [3];
  logic        rsp_error     [3];
  logic        rsp_timeout   [3];
  logic        av_chipselect [3];
  logic        av_write      [3];
  logic        av_read       [3];
  logic [3:0]  av_byteenable [3];
  logic [31:0] av_writedata  [3];
  logic [31:0] av_readdata   [3];

  // Slave model: status is done_word from read number done_at onward (0 = never).
  int          done_at   [3];
  logic [31:0] done_word [3];
  logic [31:0] filler    [3];
  int          rd_total  [3];
  int          rd_base   [3];

  int vectors    = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  generate
    for (genvar g = 0; g < 3; g++) begin : g_dut
      avalon_host #(
        .POLL_GAP ((g == 0) ? 4 : ((g == 1) ? 2 : 0)),
        .MAX_POLLS((g == 0) ? 255 : 3)
      ) u_dut (
        .clock        (clock),
        .reset        (reset),
        .cmd_valid    (cmd_valid[g]),
        .cmd_ready    (cmd_ready[g]),
        .cmd_byte     (cmd_byte[g]),
        .rsp_valid    (rsp_valid[g]),
        .rsp_byte     (rsp_byte[g]),
        .rsp_error    (rsp_error[g]),
        .rsp_timeout  (rsp_timeout[g]),
        .av_chipselect(av_chipselect[g]),
        .av_write     (av_write[g]),
        .av_read      (av_read[g]),
        .av_byteenable(av_byteenable[g]),
        .av_writedata (av_writedata[g]),
        .av_readdata  (av_readdata[g])
      );
      assign av_readdata[g] = (done_at[g] != 0 && (rd_total[g] - rd_base[g] + 1) >= done_at[g])
                              ? done_word[g] : filler[g];
      always @(posedge clock) if (av_read[g]) rd_total[g] <= rd_total[g] + 1;
    end
  endgenerate

  function automatic int gap_of(input int k);
    return (k == 0) ? 4 : ((k == 1) ? 2 : 0);
  endfunction
  function automatic int max_of(input int k);
    return (k == 0) ? 255 : 3;
  endfunction
  function automatic bit exp_done(input int k, input int d);
    return (d >= 1 && d <= max_of(k));
  endfunction
  function automatic int exp_reads(input int k, input int d);
    return exp_done(k, d) ? d : max_of(k);
  endfunction
  function automatic int exp_read_cyc(input int k, input int i);
    return 2 + gap_of(k) + i * (gap_of(k) + 1);
  endfunction
  function automatic int exp_rsp_cyc(input int k, input int n);
    return exp_read_cyc(k, n - 1) + 1;
  endfunction

  // Observations of the latest command
  int          ob_wr_n, ob_wr_cyc, ob_rsp_cyc;
  logic [31:0] ob_wd;
  logic [3:0]  ob_be;
  int          ob_reads[$];
  bit          ob_overlap, ob_proto_bad, ob_ready0, ob_ready_after;
  logic [7:0]  ob_byte, ob_byte_after;
  logic        ob_err, ob_to;

  // Starts at a negedge in the handshake cycle (cycle 0); ends at a negedge
  // in the cycle after rsp_valid.
  task automatic run_cmd(input int k, input logic [7:0] b, input int d,
                         input logic [31:0] dword, input bit hold, input logic [7:0] next_b);
    bit seen;
    done_at[k]   = d;
    done_word[k] = dword;
    filler[k]    = ($urandom | 32'h0000_0400) & ~32'h0000_0100;
    rd_base[k]   = rd_total[k];
    ob_wr_n = 0; ob_wr_cyc = -1; ob_rsp_cyc = -1; ob_wd = '0; ob_be = '0;
    ob_reads.delete();
    ob_overlap = 0; ob_proto_bad = 0;
    ob_byte = 'x; ob_err = 'x; ob_to = 'x;
    ob_ready0    = cmd_ready[k];
    cmd_valid[k] = 1'b1;
    cmd_byte[k]  = b;
    seen = 0;
    for (int cyc = 1; cyc <= 4000 && !seen; cyc++) begin
      @(negedge clock);
      if (cyc == 1 && !hold) cmd_valid[k] = 1'b0;
      if (av_write[k]) begin
        ob_wr_n++; ob_wr_cyc = cyc; ob_wd = av_writedata[k]; ob_be = av_byteenable[k];
      end
      if (av_read[k]) begin
        ob_reads.push_back(cyc);
        if (av_byteenable[k] !== 4'hF || av_writedata[k] !== 32'd0) ob_proto_bad = 1;
      end
      if (av_read[k] && av_write[k]) ob_overlap = 1;
      if (av_chipselect[k] !== (av_read[k] | av_write[k])) ob_proto_bad = 1;
      if (!av_read[k] && !av_write[k] && (av_byteenable[k] !== 4'd0 || av_writedata[k] !== 32'd0))
        ob_proto_bad = 1;
      if (cmd_ready[k] !== 1'b0) ob_proto_bad = 1;
      if (rsp_valid[k] === 1'b1) begin
        seen = 1; ob_rsp_cyc = cyc;
        ob_byte = rsp_byte[k]; ob_err = rsp_error[k]; ob_to = rsp_timeout[k];
      end
    end
    if (hold) cmd_byte[k] = next_b;
    @(negedge clock);
    ob_ready_after = cmd_ready[k];
    ob_byte_after  = rsp_byte[k];
    if (rsp_valid[k] !== 1'b0) ob_proto_bad = 1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cmd_valid[k] = 1'b1; cmd_byte[k] = 8'hFF;
      done_at[k] = 0; done_word[k] = '0; filler[k] = '0; rd_base[k] = 0;
    end
    @(posedge clock); @(negedge clock);
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if ({cmd_ready[k], rsp_valid[k], rsp_byte[k], rsp_error[k], rsp_timeout[k], av_chipselect[k],
           av_write[k], av_read[k], av_byteenable[k], av_writedata[k]} !== {1'b1, 50'd0}) begin
        miscompares++;
        $display("FAIL reset_state[%0d]: got rdy=%b rv=%b byte=%h err=%b to=%b cs=%b wr=%b rd=%b be=%h wd=%h, want rdy=1 rest 0",
                 k, cmd_ready[k], rsp_valid[k], rsp_byte[k], rsp_error[k], rsp_timeout[k],
                 av_chipselect[k], av_write[k], av_read[k], av_byteenable[k], av_writedata[k]);
      end
      cmd_valid[k] = 1'b0;
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_first_poll;
    run_cmd(0, 8'hA5, 1, 32'h0000_013C, 0, 8'h00);
    vectors++; if (ob_wr_cyc !== 1 || ob_wr_n !== 1) begin miscompares++;
      $display("FAIL first_write_cycle: got cyc %0d n %0d, want cyc 1 n 1", ob_wr_cyc, ob_wr_n); end
    vectors++; if ({ob_wd, ob_be} !== {32'h0000_00A5, 4'b0001}) begin miscompares++;
      $display("FAIL first_writedata: got %h/%b, want 000000a5/0001", ob_wd, ob_be); end
    vectors++; if (ob_reads.size() !== 1 || ob_reads[0] !== 6) begin miscompares++;
      $display("FAIL first_read_cycle: got %0d reads first at %0d, want 1 read at 6", ob_reads.size(), ob_reads[0]); end
    vectors++; if (ob_rsp_cyc !== 7 || {ob_byte, ob_err, ob_to} !== {8'h3C, 2'b00}) begin miscompares++;
      $display("FAIL first_rsp: got cyc %0d byte %h err %b to %b, want cyc 7 byte 3c 0 0", ob_rsp_cyc, ob_byte, ob_err, ob_to); end
  endtask

  task automatic test_multi_poll;
    run_cmd(0, 8'h3E, 4, 32'h0000_0507, 0, 8'h00);
    vectors++; if (ob_reads.size() !== 4) begin miscompares++;
      $display("FAIL multi_read_count: got %0d, want 4", ob_reads.size()); end
    for (int i = 1; i < ob_reads.size(); i++) begin
      vectors++; if (ob_reads[i] - ob_reads[i-1] !== 5) begin miscompares++;
        $display("FAIL multi_read_spacing[%0d]: got %0d, want 5", i, ob_reads[i] - ob_reads[i-1]); end
    end
    vectors++; if ({ob_byte, ob_err, ob_to} !== {8'h07, 2'b10} || ob_rsp_cyc !== 22) begin miscompares++;
      $display("FAIL multi_rsp: got byte %h err %b to %b cyc %0d, want 07 1 0 cyc 22", ob_byte, ob_err, ob_to, ob_rsp_cyc); end
  endtask

  task automatic test_timeout;
    run_cmd(1, 8'h81, 0, 32'h0, 0, 8'h00);
    vectors++; if (ob_reads.size() !== 3 || ob_rsp_cyc !== 11) begin miscompares++;
      $display("FAIL timeout_reads: got %0d reads rsp cyc %0d, want 3 reads rsp cyc 11", ob_reads.size(), ob_rsp_cyc); end
    vectors++; if ({ob_byte, ob_err, ob_to} !== {8'h00, 2'b01}) begin miscompares++;
      $display("FAIL timeout_rsp: got byte %h err %b to %b, want 00 0 1", ob_byte, ob_err, ob_to); end
    vectors++; if (ob_ready_after !== 1'b1) begin miscompares++;
      $display("FAIL timeout_ready_after: got %b, want 1", ob_ready_after); end
  endtask

  task automatic test_done_last;
    run_cmd(1, 8'h42, 3, 32'hFFFF_F155 & ~32'h400, 0, 8'h00);
    vectors++; if ({ob_byte, ob_err, ob_to} !== {8'h55, 2'b00} || ob_reads.size() !== 3) begin miscompares++;
      $display("FAIL done_last_rsp: got byte %h err %b to %b reads %0d, want 55 0 0 reads 3", ob_byte, ob_err, ob_to, ob_reads.size()); end
  endtask

  task automatic test_back_to_back;
    run_cmd(2, 8'h11, 1, 32'h0000_01A1, 1, 8'h22);
    vectors++; if (ob_wr_cyc !== 1 || ob_wd !== 32'h11 || ob_reads.size() !== 1 || ob_reads[0] !== 2 || ob_rsp_cyc !== 3) begin
      miscompares++;
      $display("FAIL b2b_first: got wr %0d wd %h reads %0d@%0d rsp %0d, want wr 1 wd 11 1@2 rsp 3",
               ob_wr_cyc, ob_wd, ob_reads.size(), ob_reads[0], ob_rsp_cyc); end
    vectors++; if (ob_overlap !== 0 || ob_byte !== 8'hA1) begin miscompares++;
      $display("FAIL b2b_first_rsp: got overlap %b byte %h, want 0 a1", ob_overlap, ob_byte); end
    run_cmd(2, 8'h22, 1, 32'h0000_05B2, 0, 8'h00);
    vectors++; if (ob_ready0 !== 1'b1 || ob_wr_cyc !== 1 || ob_wd !== 32'h22 || ob_rsp_cyc !== 3) begin miscompares++;
      $display("FAIL b2b_second: got rdy0 %b wr %0d wd %h rsp %0d, want 1 1 22 3", ob_ready0, ob_wr_cyc, ob_wd, ob_rsp_cyc); end
    vectors++; if (ob_overlap !== 0 || {ob_byte, ob_err} !== {8'hB2, 1'b1}) begin miscompares++;
      $display("FAIL b2b_second_rsp: got overlap %b byte %h err %b, want 0 b2 1", ob_overlap, ob_byte, ob_err); end
  endtask

  task automatic test_async_reset;
    int stops[2] = '{3, 6};
    int spurious;
    for (int s = 0; s < 2; s++) begin
      done_at[0] = 0;
      filler[0]  = 32'h0000_04EE;
      cmd_valid[0] = 1'b1; cmd_byte[0] = 8'h5A;
      for (int c = 1; c <= stops[s]; c++) begin
        @(negedge clock);
        cmd_valid[0] = 1'b0;
      end
      vectors++; if (av_read[0] !== (stops[s] == 6)) begin miscompares++;
        $display("FAIL arst_pre_read[%0d]: got %b, want %b", s, av_read[0], stops[s] == 6); end
      #2 reset = 1'b1;
      #1;
      vectors++;
      if ({av_chipselect[0], av_write[0], av_read[0], av_byteenable[0], av_writedata[0], cmd_ready[0], rsp_valid[0], rsp_byte[0]}
          !== {3'b000, 4'h0, 32'h0, 1'b1, 1'b0, 8'h00}) begin
        miscompares++;
        $display("FAIL arst_immediate[%0d]: got cs %b wr %b rd %b be %h wd %h rdy %b rv %b byte %h, want 0 0 0 0 0 1 0 00",
                 s, av_chipselect[0], av_write[0], av_read[0], av_byteenable[0], av_writedata[0],
                 cmd_ready[0], rsp_valid[0], rsp_byte[0]);
      end
      @(negedge clock);
      reset = 1'b0;
      spurious = 0;
      for (int c = 0; c < 40; c++) begin
        @(negedge clock);
        if (rsp_valid[0] || av_chipselect[0] || !cmd_ready[0]) spurious++;
      end
      vectors++; if (spurious !== 0) begin miscompares++;
        $display("FAIL arst_no_response[%0d]: got %0d active cycles, want 0", s, spurious); end
    end
    run_cmd(0, 8'hC3, 2, 32'h0000_01C3, 0, 8'h00);
    vectors++; if (ob_rsp_cyc !== 12 || {ob_byte, ob_err, ob_to} !== {8'hC3, 2'b00} || ob_wd !== 32'hC3) begin miscompares++;
      $display("FAIL arst_recover: got cyc %0d byte %h err %b to %b wd %h, want cyc 12 c3 0 0 wd c3",
               ob_rsp_cyc, ob_byte, ob_err, ob_to, ob_wd); end
  endtask

  task automatic test_random;
    for (int it = 0; it < 15; it++) begin
      int k, d, n;
      logic [7:0]  b;
      logic [31:0] w;
      logic [7:0]  eb;
      logic        ee, et;
      k = it % 3;
      b = 8'($urandom);
      w = $urandom | 32'h0000_0100;
      d = (k == 0) ? int'($urandom_range(1, 5)) : int'($urandom_range(0, 4));
      n  = exp_reads(k, d);
      eb = exp_done(k, d) ? w[7:0] : 8'h00;
      ee = exp_done(k, d) ? w[10] : 1'b0;
      et = !exp_done(k, d);
      run_cmd(k, b, d, w, 0, 8'h00);
      vectors++; if (ob_wr_n !== 1 || ob_wr_cyc !== 1 || ob_wd !== {24'd0, b} || ob_be !== 4'b0001) begin miscompares++;
        $display("FAIL rnd_write[%0d]: got n %0d cyc %0d wd %h be %b, want 1 1 %h 0001", it, ob_wr_n, ob_wr_cyc, ob_wd, b, ob_be); end
      vectors++; if (ob_reads.size() !== n) begin miscompares++;
        $display("FAIL rnd_read_count[%0d]: got %0d, want %0d", it, ob_reads.size(), n); end
      for (int i = 0; i < ob_reads.size() && i < n; i++) begin
        vectors++; if (ob_reads[i] !== exp_read_cyc(k, i)) begin miscompares++;
          $display("FAIL rnd_read_cycle[%0d.%0d]: got %0d, want %0d", it, i, ob_reads[i], exp_read_cyc(k, i)); end
      end
      vectors++; if (ob_rsp_cyc !== exp_rsp_cyc(k, n)) begin miscompares++;
        $display("FAIL rnd_rsp_cycle[%0d]: got %0d, want %0d", it, ob_rsp_cyc, exp_rsp_cyc(k, n)); end
      vectors++; if ({ob_byte, ob_err, ob_to} !== {eb, ee, et}) begin miscompares++;
        $display("FAIL rnd_rsp_fields[%0d]: got %h %b %b, want %h %b %b", it, ob_byte, ob_err, ob_to, eb, ee, et); end
      vectors++; if (ob_overlap !== 0 || ob_proto_bad !== 0) begin miscompares++;
        $display("FAIL rnd_bus_protocol[%0d]: got overlap %b bad %b, want 0 0", it, ob_overlap, ob_proto_bad); end
      vectors++; if (ob_ready_after !== 1'b1 || ob_byte_after !== eb) begin miscompares++;
        $display("FAIL rnd_after_rsp[%0d]: got rdy %b byte %h, want 1 %h", it, ob_ready_after, ob_byte_after, eb); end
    end
  endtask

  initial begin
    test_reset();
    test_first_poll();
    test_multi_poll();
    test_timeout();
    test_done_last();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
